// File: rtl/fp_mul_arbiter.sv
// Two-requester round-robin front end sharing a single FP32 multiplier (MultiOp).
// Optional statistics counters are enabled by defining FP_MUL_ARB_STATS_EN.

module MultiOp (
    input  logic [31:0] para1,
    input  logic [31:0] para2,
    output logic [31:0] out,
    output logic        under_overflow
);
    logic [47:0]       prod;
    logic [23:0]       mant;
    logic              guard;
    logic              sticky;
    logic [24:0]       mant_r;
    logic signed [9:0] exp_v;
    logic              sign;

    always_comb begin
        prod           = 48'({1'b1, para1[22:0]}) * 48'({1'b1, para2[22:0]});
        sign           = para1[31] ^ para2[31];
        mant           = '0;
        guard          = 1'b0;
        sticky         = 1'b0;
        mant_r         = '0;
        exp_v          = $signed({2'b00, para1[30:23]}) + $signed({2'b00, para2[30:23]}) - 10'sd127;
        out            = {sign, 31'b0};
        under_overflow = 1'b0;

        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_v  = exp_v + 10'sd1;
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end

        // Round to nearest, ties to even; a carry out renormalises the mantissa.
        mant_r = {1'b0, mant} + 25'(guard & (sticky | mant[0]));
        if (mant_r[24]) begin
            exp_v = exp_v + 10'sd1;
        end

        if (para1[30:23] == 8'd0 || para2[30:23] == 8'd0) begin
            out = {sign, 31'b0};
        end else if (exp_v >= 10'sd255) begin
            out            = {sign, 8'hFF, 23'b0};
            under_overflow = 1'b1;
        end else if (exp_v <= 10'sd0) begin
            out            = {sign, 31'b0};
            under_overflow = 1'b1;
        end else begin
            out = {sign, exp_v[7:0], (mant_r[24] ? mant_r[23:1] : mant_r[22:0])};
        end
    end
endmodule

// state | meaning
// IDLE  | waiting for a request; grants one requester combinationally
// EXEC  | multiplier evaluating latched operands; result captured at end
// RESP  | result presented on resp_*; held until the consumer accepts it
module fp_mul_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [31:0]      req0_para1,
    input  logic [31:0]      req0_para2,
    input  logic [31:0]      req1_para1,
    input  logic [31:0]      req1_para2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_out,
    output logic             resp_uof,
    output logic             resp_id
`ifdef FP_MUL_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_cnt0,
    output logic [CNT_W-1:0] stat_cnt1,
    output logic [CNT_W-1:0] stat_uof_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_grant;
    logic        grant;
    logic        hs_req;
    logic        hs_resp;
    logic [31:0] op_a, op_b;
    logic [31:0] mul_out;
    logic        mul_uof;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    MultiOp u_mult (
        .para1          (op_a),
        .para2          (op_b),
        .out            (mul_out),
        .under_overflow (mul_uof)
    );

    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end
    end

    assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = !rst && (state_q == IDLE) && req1_valid &&  grant;
    assign hs_req     = req0_ready || req1_ready;
    assign resp_valid = (state_q == RESP);
    assign hs_resp    = resp_valid && resp_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs_req)  state_d = EXEC;
            EXEC:                 state_d = RESP;
            RESP:    if (hs_resp) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            resp_out   <= '0;
            resp_uof   <= 1'b0;
            resp_id    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs_req) begin
                op_a       <= grant ? req1_para1 : req0_para1;
                op_b       <= grant ? req1_para2 : req0_para2;
                resp_id    <= grant;
                last_grant <= grant;
            end
            if (state_q == EXEC) begin
                resp_out <= mul_out;
                resp_uof <= mul_uof;
            end
        end
    end

`ifdef FP_MUL_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt0    <= '0;
            stat_cnt1    <= '0;
            stat_uof_cnt <= '0;
        end else begin
            if (req0_ready && stat_cnt0 != CNT_MAX) begin
                stat_cnt0 <= stat_cnt0 + CNT_W'(1);
            end
            if (req1_ready && stat_cnt1 != CNT_MAX) begin
                stat_cnt1 <= stat_cnt1 + CNT_W'(1);
            end
            if (hs_resp && resp_uof && stat_uof_cnt != CNT_MAX) begin
                stat_uof_cnt <= stat_uof_cnt + CNT_W'(1);
            end
        end
    end
`endif
endmodule
